computational_unit_banked: RTL
==============================

# computational_unit_banked

Parametrised successor to the 4-bit microcontroller computational unit: the same source-select data bus, x/y/m/i/r register set and 8-function ALU, generalised to DW-bit data and CTX_DEPTH banked contexts for nested subroutines. Each context holds its own x0, y0 and o_reg. The block sits between the program sequencer and the I/O pins. The sequencer drives decoded register enables, source selects and call/return strobes; the block returns the zero flag and the context stack status.

## Interface
- DW, 4: data width of every register, bus and ALU operand.
- CTX_DEPTH, 4: number of x0/y0/o_reg banks (level 0 = main program), ≥2.
- clk  in  1  single clock, all state on rising edge.
- sync_reset  in  1  synchronous, active-high reset.
- source_sel  in  4  data_bus source: 0 x0, 1 x1, 2 y0, 3 y1, 4 r, 5 m, 6 i, 7 dm, 8 pm_data, 9 i_pins, 10-15 zero.
- pm_data  in  DW  immediate operand from instruction register.
- alu_op  in  4  bit3 = no-op qualifier, bits[2:0] = function.
- i_pins, dm  in  DW  external inputs.
- reg_en  in  9  write enables: 0 x0, 1 x1, 2 y0, 3 y1, 4 r, 5 m, 6 i, 7 unused, 8 o_reg.
- i_sel, x_sel, y_sel  in  1  i source (0 bus, 1 i+m); ALU x (0 x0, 1 x1); ALU y (0 y0, 1 y1).
- ctx_push, ctx_pop  in  1  call / return strobes.
- data_bus  out  DW  combinational bus value.
- o_reg, i, r  out  DW  current-bank o_reg; index register; result register.
- r_eq_0  out  1  zero flag.
- ctx_level  out  $clog2(CTX_DEPTH)  active bank.
- ctx_ovf, ctx_unf  out  1  sticky push-at-top / pop-at-bottom errors.

## Operation
- x0, y0 and o_reg reads and writes always address bank ctx_level. x1, y1, m, i and r are shared by all banks.
- ALU functions, with x and y as selected:
  - 0 with bit3 = 0: -x (two's complement).
  - 1: x-y. 2: x+y. Both mod 2^DW.
  - 3: product bits [2DW-1:DW]. 4: product bits [DW-1:0]. The product is unsigned 2DW-bit.
  - 5: x^y. 6: x&y.
  - 7 with bit3 = 0: ~x.
  - 0 or 7 with bit3 = 1: no-op. r and r_eq_0 hold even when reg_en[4] = 1.
- reg_en[4] with a non-no-op function: r <= alu result; r_eq_0 <= (result == 0).
- i with reg_en[6]: i <= data_bus, or i <= i+m (mod 2^DW) when i_sel = 1.
- ctx_push:
  - If ctx_level < CTX_DEPTH-1: level +1, and the entered bank's x0/y0/o_reg are cleared to 0.
  - At the top: level unchanged, ctx_ovf <= 1.
- ctx_pop:
  - If level > 0: level -1. The exited bank keeps its contents.
  - At level 0: ctx_unf <= 1.
- Push and pop in the same cycle: no level change, no clear, no flags.
- A register write in the same cycle as push/pop targets the old level.
- ctx_ovf and ctx_unf clear only on sync_reset.

## Timing
- data_bus, o_reg and ALU inputs are combinational. All register writes take effect one cycle after the enable. ALU result is in r next cycle.
- New ctx_level is visible the cycle after the strobe. o_reg switches banks the same cycle.
- sync_reset has priority over every enable and strobe. It sets:
  - all banks, x1, y1, m, i and r to 0;
  - r_eq_0 to 1;
  - ctx_level to 0;
  - ctx_ovf, ctx_unf and c_flag to 0.

## Configuration
- COMPUTATIONAL_UNIT_CARRY_EN defined:
  - Adds output c_flag (1 bit), updated only when reg_en[4] = 1 and the function is add or sub.
  - Add: c_flag = carry out of bit DW-1. Sub: c_flag = borrow (x < y unsigned).
  - c_flag is banked per context: it is saved on push and restored on pop.
  - A newly entered bank has c_flag = 0.
- Undefined: no c_flag port and no carry logic.

## Structure
- Package computational_unit_pkg holds:
  - source_sel encodings SRC_X0..SRC_IPINS;
  - ALU function constants ALU_NEG..ALU_NOT and ALU_NOP_BIT;
  - reg_en bit indices.
- One sub-module, cu_context_bank:
  - banked x0/y0/o_reg (and c_flag) storage;
  - level counter with overflow/underflow logic;
  - ports are write enables, data_bus, push, pop, and current-bank read outputs.

## Test plan
- Reset check: assert sync_reset 1 cycle -> r=0, r_eq_0=1, ctx_level=0, o_reg=0, all flags 0.
- Arithmetic (DW=4), x0=9, y0=7:
  - op 2 -> r=0, r_eq_0=1; op 1 -> r=2; op 3 -> r=3; op 4 -> r=15 (63=0x3F).
  - op 8 (no-op) with reg_en[4] -> r and r_eq_0 held.
- Banking: level 0 writes x0=5, o_reg=A; push -> x0 reads 0 and o_reg=0; write x0=3; pop -> x0=5, o_reg=A.
- Stack limits (CTX_DEPTH=4): 4 pushes -> level 3, ctx_ovf=1; 4 pops -> level 0, ctx_unf=1; both flags stay set until reset.
- Simultaneous events:
  - push+pop with reg_en[0], data_bus=6 at level 1 -> level stays 1, bank-1 x0=6.
  - sync_reset during push -> level 0.
- Index: m=5, i=E, i_sel=1 with reg_en[6] -> i=3 (wrap).
- CARRY_EN: F+1 -> r=0, c_flag=1; 2-3 -> c_flag=1; push -> c_flag=0; pop -> c_flag=1.

Source files
------------

// File: rtl/computational_unit_banked_pkg.sv
// Shared encodings for the banked computational unit: bus sources, ALU functions, enable bits.
// Optional carry flag is enabled with the COMPUTATIONAL_UNIT_CARRY_EN macro.
package computational_unit_pkg;

  localparam logic [3:0] SRC_X0    = 4'd0;
  localparam logic [3:0] SRC_X1    = 4'd1;
  localparam logic [3:0] SRC_Y0    = 4'd2;
  localparam logic [3:0] SRC_Y1    = 4'd3;
  localparam logic [3:0] SRC_R     = 4'd4;
  localparam logic [3:0] SRC_M     = 4'd5;
  localparam logic [3:0] SRC_I     = 4'd6;
  localparam logic [3:0] SRC_DM    = 4'd7;
  localparam logic [3:0] SRC_PM    = 4'd8;
  localparam logic [3:0] SRC_IPINS = 4'd9;

  typedef enum logic [2:0] {
    ALU_NEG  = 3'd0,
    ALU_SUB  = 3'd1,
    ALU_ADD  = 3'd2,
    ALU_MULH = 3'd3,
    ALU_MULL = 3'd4,
    ALU_XOR  = 3'd5,
    ALU_AND  = 3'd6,
    ALU_NOT  = 3'd7
  } alu_func_e;

  localparam int ALU_NOP_BIT = 3;

  localparam int EN_X0 = 0;
  localparam int EN_X1 = 1;
  localparam int EN_Y0 = 2;
  localparam int EN_Y1 = 3;
  localparam int EN_R  = 4;
  localparam int EN_M  = 5;
  localparam int EN_I  = 6;
  localparam int EN_O  = 8;

  // The qualifier bit only turns the two unary functions into a no-op.
  function automatic logic is_nop(input logic [3:0] op);
    return op[ALU_NOP_BIT] && ((op[2:0] == ALU_NEG) || (op[2:0] == ALU_NOT));
  endfunction

endpackage

// File: rtl/computational_unit_banked_if.sv
// Sequencer-facing bundle of the banked computational unit.
// c_flag exists only when COMPUTATIONAL_UNIT_CARRY_EN is defined.
interface computational_unit_banked_if #(
  parameter int DW        = 4,
  parameter int CTX_DEPTH = 4
);
  localparam int LW = $clog2(CTX_DEPTH);

  logic [3:0]    source_sel;
  logic [DW-1:0] pm_data;
  logic [3:0]    alu_op;
  logic [DW-1:0] i_pins;
  logic [DW-1:0] dm;
  logic [8:0]    reg_en;
  logic          i_sel;
  logic          x_sel;
  logic          y_sel;
  logic          ctx_push;
  logic          ctx_pop;
  logic [DW-1:0] data_bus;
  logic [DW-1:0] o_reg;
  logic [DW-1:0] i;
  logic [DW-1:0] r;
  logic          r_eq_0;
  logic [LW-1:0] ctx_level;
  logic          ctx_ovf;
  logic          ctx_unf;
`ifdef COMPUTATIONAL_UNIT_CARRY_EN
  logic          c_flag;
`endif

  modport master (
    output source_sel, pm_data, alu_op, i_pins, dm, reg_en,
    output i_sel, x_sel, y_sel, ctx_push, ctx_pop,
    input  data_bus, o_reg, i, r, r_eq_0, ctx_level, ctx_ovf, ctx_unf
`ifdef COMPUTATIONAL_UNIT_CARRY_EN
    , input c_flag
`endif
  );

  modport slave (
    input  source_sel, pm_data, alu_op, i_pins, dm, reg_en,
    input  i_sel, x_sel, y_sel, ctx_push, ctx_pop,
    output data_bus, o_reg, i, r, r_eq_0, ctx_level, ctx_ovf, ctx_unf
`ifdef COMPUTATIONAL_UNIT_CARRY_EN
    , output c_flag
`endif
  );

endinterface

// File: rtl/computational_unit_banked_context_bank.sv
// Per-context x0/y0/o_reg (and c_flag with COMPUTATIONAL_UNIT_CARRY_EN) storage
// plus the context level counter with sticky overflow/underflow flags.
module cu_context_bank
  import computational_unit_pkg::*;
#(
  parameter  int DW        = 4,
  parameter  int CTX_DEPTH = 4,
  localparam int LW        = $clog2(CTX_DEPTH)
) (
  input  logic          clk,
  input  logic          sync_reset,
  input  logic          wr_x0,
  input  logic          wr_y0,
  input  logic          wr_o,
  input  logic [DW-1:0] data_bus,
  input  logic          push,
  input  logic          pop,
`ifdef COMPUTATIONAL_UNIT_CARRY_EN
  input  logic          c_wr,
  input  logic          c_in,
  output logic          c_flag,
`endif
  output logic [DW-1:0] x0,
  output logic [DW-1:0] y0,
  output logic [DW-1:0] o_reg,
  output logic [LW-1:0] level,
  output logic          ovf,
  output logic          unf
);

  localparam logic [LW-1:0] TOP_LEVEL = LW'(CTX_DEPTH - 1);

  logic [DW-1:0] x0_q [CTX_DEPTH];
  logic [DW-1:0] x0_d [CTX_DEPTH];
  logic [DW-1:0] y0_q [CTX_DEPTH];
  logic [DW-1:0] y0_d [CTX_DEPTH];
  logic [DW-1:0] o_q  [CTX_DEPTH];
  logic [DW-1:0] o_d  [CTX_DEPTH];
`ifdef COMPUTATIONAL_UNIT_CARRY_EN
  logic          c_q  [CTX_DEPTH];
  logic          c_d  [CTX_DEPTH];
`endif
  logic [LW-1:0] level_q, level_d, next_level;
  logic          ovf_q, ovf_d, unf_q, unf_d;
  logic          push_only, pop_only;

  assign next_level = level_q + LW'(1);
  assign push_only  = push && !pop;
  assign pop_only   = pop && !push;

  // Writes land in the current bank; a push then clears the bank being entered.
  always_comb begin
    x0_d    = x0_q;
    y0_d    = y0_q;
    o_d     = o_q;
    level_d = level_q;
    ovf_d   = ovf_q;
    unf_d   = unf_q;
`ifdef COMPUTATIONAL_UNIT_CARRY_EN
    c_d     = c_q;
    if (c_wr) c_d[level_q] = c_in;
`endif
    if (wr_x0) x0_d[level_q] = data_bus;
    if (wr_y0) y0_d[level_q] = data_bus;
    if (wr_o)  o_d[level_q]  = data_bus;
    if (push_only) begin
      if (level_q != TOP_LEVEL) begin
        level_d          = next_level;
        x0_d[next_level] = '0;
        y0_d[next_level] = '0;
        o_d[next_level]  = '0;
`ifdef COMPUTATIONAL_UNIT_CARRY_EN
        c_d[next_level]  = 1'b0;
`endif
      end else begin
        ovf_d = 1'b1;
      end
    end
    if (pop_only) begin
      if (level_q != '0) level_d = level_q - LW'(1);
      else               unf_d   = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (sync_reset) begin
      for (int k = 0; k < CTX_DEPTH; k++) begin
        x0_q[k] <= '0;
        y0_q[k] <= '0;
        o_q[k]  <= '0;
`ifdef COMPUTATIONAL_UNIT_CARRY_EN
        c_q[k]  <= 1'b0;
`endif
      end
      level_q <= '0;
      ovf_q   <= 1'b0;
      unf_q   <= 1'b0;
    end else begin
      x0_q    <= x0_d;
      y0_q    <= y0_d;
      o_q     <= o_d;
`ifdef COMPUTATIONAL_UNIT_CARRY_EN
      c_q     <= c_d;
`endif
      level_q <= level_d;
      ovf_q   <= ovf_d;
      unf_q   <= unf_d;
    end
  end

  assign x0    = x0_q[level_q];
  assign y0    = y0_q[level_q];
  assign o_reg = o_q[level_q];
  assign level = level_q;
  assign ovf   = ovf_q;
  assign unf   = unf_q;
`ifdef COMPUTATIONAL_UNIT_CARRY_EN
  assign c_flag = c_q[level_q];
`endif

endmodule

// File: rtl/computational_unit_banked.sv
// Banked computational unit: source-select bus, shared x1/y1/m/i/r, 8-function ALU.
// Define COMPUTATIONAL_UNIT_CARRY_EN to add the banked carry/borrow flag c_flag.
module computational_unit_banked
  import computational_unit_pkg::*;
#(
  parameter int DW        = 4,
  parameter int CTX_DEPTH = 4
) (
  input logic                 clk,
  input logic                 sync_reset,
  computational_unit_banked_if.slave cu
);

  localparam int LW = $clog2(CTX_DEPTH);

  logic [DW-1:0]   x0, y0, o_reg_w, data_bus;
  logic [DW-1:0]   x1_q, x1_d, y1_q, y1_d, m_q, m_d, i_q, i_d, r_q, r_d;
  logic            r_eq_0_q, r_eq_0_d;
  logic [DW-1:0]   alu_x, alu_y, alu_res;
  logic [2*DW-1:0] product;
  logic [LW-1:0]   level;
  logic            ovf, unf;
  alu_func_e       func;
  logic            nop;
  logic            unused_reg_en7;

  assign unused_reg_en7 = cu.reg_en[7];

`ifdef COMPUTATIONAL_UNIT_CARRY_EN
  logic [DW:0] sum_ext;
  logic        c_wr, c_in, c_flag_w;

  assign sum_ext = {1'b0, alu_x} + {1'b0, alu_y};
  assign c_wr    = cu.reg_en[EN_R] && ((func == ALU_ADD) || (func == ALU_SUB));
  assign c_in    = (func == ALU_ADD) ? sum_ext[DW] : (alu_x < alu_y);
  assign cu.c_flag = c_flag_w;
`endif

  cu_context_bank #(.DW(DW), .CTX_DEPTH(CTX_DEPTH)) u_bank (
    .clk        (clk),
    .sync_reset (sync_reset),
    .wr_x0      (cu.reg_en[EN_X0]),
    .wr_y0      (cu.reg_en[EN_Y0]),
    .wr_o       (cu.reg_en[EN_O]),
    .data_bus   (data_bus),
    .push       (cu.ctx_push),
    .pop        (cu.ctx_pop),
`ifdef COMPUTATIONAL_UNIT_CARRY_EN
    .c_wr       (c_wr),
    .c_in       (c_in),
    .c_flag     (c_flag_w),
`endif
    .x0         (x0),
    .y0         (y0),
    .o_reg      (o_reg_w),
    .level      (level),
    .ovf        (ovf),
    .unf        (unf)
  );

  always_comb begin
    data_bus = '0;
    case (cu.source_sel)
      SRC_X0:    data_bus = x0;
      SRC_X1:    data_bus = x1_q;
      SRC_Y0:    data_bus = y0;
      SRC_Y1:    data_bus = y1_q;
      SRC_R:     data_bus = r_q;
      SRC_M:     data_bus = m_q;
      SRC_I:     data_bus = i_q;
      SRC_DM:    data_bus = cu.dm;
      SRC_PM:    data_bus = cu.pm_data;
      SRC_IPINS: data_bus = cu.i_pins;
      default:   data_bus = '0;
    endcase
  end

  assign alu_x   = cu.x_sel ? x1_q : x0;
  assign alu_y   = cu.y_sel ? y1_q : y0;
  assign product = {{DW{1'b0}}, alu_x} * {{DW{1'b0}}, alu_y};
  assign func    = alu_func_e'(cu.alu_op[2:0]);
  assign nop     = is_nop(cu.alu_op);

  always_comb begin
    alu_res = '0;
    case (func)
      ALU_NEG:  alu_res = -alu_x;
      ALU_SUB:  alu_res = alu_x - alu_y;
      ALU_ADD:  alu_res = alu_x + alu_y;
      ALU_MULH: alu_res = product[2*DW-1:DW];
      ALU_MULL: alu_res = product[DW-1:0];
      ALU_XOR:  alu_res = alu_x ^ alu_y;
      ALU_AND:  alu_res = alu_x & alu_y;
      ALU_NOT:  alu_res = ~alu_x;
      default:  alu_res = '0;
    endcase
  end

  always_comb begin
    x1_d     = x1_q;
    y1_d     = y1_q;
    m_d      = m_q;
    i_d      = i_q;
    r_d      = r_q;
    r_eq_0_d = r_eq_0_q;
    if (cu.reg_en[EN_X1]) x1_d = data_bus;
    if (cu.reg_en[EN_Y1]) y1_d = data_bus;
    if (cu.reg_en[EN_M])  m_d  = data_bus;
    if (cu.reg_en[EN_I])  i_d  = cu.i_sel ? (i_q + m_q) : data_bus;
    if (cu.reg_en[EN_R] && !nop) begin
      r_d      = alu_res;
      r_eq_0_d = (alu_res == '0);
    end
  end

  always_ff @(posedge clk) begin
    if (sync_reset) begin
      x1_q     <= '0;
      y1_q     <= '0;
      m_q      <= '0;
      i_q      <= '0;
      r_q      <= '0;
      r_eq_0_q <= 1'b1;
    end else begin
      x1_q     <= x1_d;
      y1_q     <= y1_d;
      m_q      <= m_d;
      i_q      <= i_d;
      r_q      <= r_d;
      r_eq_0_q <= r_eq_0_d;
    end
  end

  assign cu.data_bus  = data_bus;
  assign cu.o_reg     = o_reg_w;
  assign cu.i         = i_q;
  assign cu.r         = r_q;
  assign cu.r_eq_0    = r_eq_0_q;
  assign cu.ctx_level = level;
  assign cu.ctx_ovf   = ovf;
  assign cu.ctx_unf   = unf;

endmodule
